ula_md_iterativa: RTL
=====================

# ula_md_iterativa

Parametrised iterative multiply/divide unit, the sequential companion to the datapath's combinational `ula`. It executes the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with a fixed, data-independent latency of WIDTH+1 cycles. It uses a start/busy/done handshake, so the multicycle control FSM can hold in an execute stage until `done`. The result register feeds the same ALU-result backup path as `ula`.

## Interface
- WIDTH, 32, operand/result width; legal range 4..64.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while `busy`=0.
- op  in  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  operand a (multiplicand / dividend); sampled with `start`.
- b  in  WIDTH  operand b (multiplier / divisor); sampled with `start`.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; `out` is valid from this cycle on.
- out  out  WIDTH  result register; holds until the next completion.
- zero  out  1  `out`==0, combinational from the result register.

## Operation
- States: IDLE, CALC, FIX. Reset forces IDLE.
- IDLE + start:
  - latch `op`;
  - latch |a| and |b| as unsigned magnitudes; signedness comes from `op`: MULHSU treats only `a` as signed; MULHU/DIVU/REMU treat both as unsigned;
  - latch the result sign flags;
  - clear the iteration counter (clog2(WIDTH+1) bits) and the 2*WIDTH accumulator;
  - go to CALC.
- CALC (WIDTH cycles, one bit per cycle):
  - multiply: shift-add, LSB of multiplier first, with a 2*WIDTH-bit product;
  - divide: restoring, MSB of dividend first, WIDTH-bit remainder and quotient;
  - go to FIX when the counter reaches WIDTH-1.
- FIX (1 cycle):
  - apply sign correction (two's-complement negate of the full 2*WIDTH product, or of quotient/remainder);
  - select the result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder;
  - load `out`, pulse `done`, go to IDLE.
- Special cases: the result is forced in FIX, but the full latency is still taken.
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return `a`.
  - Signed overflow (a = most negative, b = -1): DIV returns most negative; REM returns 0.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- `start` while `busy`=1 is ignored; operands are not re-sampled.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `out`=0, `zero`=1;
  - counter and accumulators 0.
- Reset mid-operation:
  - the operation is abandoned with no `done` pulse;
  - reset values are reached at the next edge.
- `start` is sampled at edge E0. `busy`=1 from E0 to E0+WIDTH+1. `done`=1 and `out` are valid in the cycle after edge E0+WIDTH+1. Latency is WIDTH+1 cycles.
- Back-to-back: `start` in the `done` cycle is accepted (`busy`=0 there). The new operation completes WIDTH+1 cycles later; `out` keeps the previous result until then.
- `rst` and `start` in the same cycle: reset wins.
- `done` is never high for two consecutive cycles.
- `zero` tracks `out` only; it is not updated during CALC.

## Test plan
- Reset, then MUL a=7, b=0xFFFFFFFD (WIDTH=32):
  - `done` pulses exactly 33 cycles after the start edge;
  - `out`=0xFFFFFFEB, `zero`=0.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corner cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0 with `zero`=1;
  - each still takes 33 cycles.
- Handshake:
  - second `start` with different operands at cycle 10 of an operation is ignored; the first result is unchanged;
  - `start` in the `done` cycle runs back-to-back with a correct second result.
- Reset mid-operation:
  - assert `rst` at cycle 15 of a DIV;
  - next cycle shows `busy`=0, `out`=0, `zero`=1, and no `done` pulse;
  - a subsequent MUL 3×4 -> 12.

Source files
------------

// File: rtl/ula_md_iterativa.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed WIDTH+1 cycle latency with a start/busy/done handshake.
module ula_md_iterativa #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opa, opb;
  logic [2:0]         op_q;
  logic               a_neg, b_neg, b_zero, ovf;

  logic               a_signed, b_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, result;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CNT_LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand signedness only matters at latch time; the iteration works on magnitudes.
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    mag_a    = (a_signed && a[WIDTH-1]) ? -a : a;
    mag_b    = (b_signed && b[WIDTH-1]) ? -b : b;
  end

  // Multiply keeps the partial product in acc; divide keeps remainder (high) and quotient (low).
  always_comb begin
    acc_hi    = acc[2*WIDTH-1:WIDTH];
    acc_lo    = acc[WIDTH-1:0];
    mul_sum   = {1'b0, acc_hi} + (opb[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, opa[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ok    = ~div_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      op_q   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            opa    <= mag_a;
            opb    <= mag_b;
            a_neg  <= a_signed && a[WIDTH-1];
            b_neg  <= b_signed && b[WIDTH-1];
            b_zero <= (b == '0);
            ovf    <= op[2] && !op[0] && (a == MOST_NEG) && (&b);
            cnt    <= '0;
            acc    <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_q[2]) begin
            acc <= {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                    acc_lo[WIDTH-2:0], div_ok};
            opa <= {opa[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc_lo[WIDTH-1:1]};
            opb <= {1'b0, opb[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Remainder takes the dividend's sign, so with a zero divisor it reproduces a exactly.
  always_comb begin
    prod_fix = (a_neg ^ b_neg) ? -acc : acc;
    quot_fix = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
    rem_fix  = a_neg ? -acc_hi : acc_hi;
    result   = '0;
    case (op_q)
      OP_MUL:                        result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               result = b_zero ? {WIDTH{1'b1}} : (ovf ? MOST_NEG : quot_fix);
      OP_REM, OP_REMU:               result = ovf ? '0 : rem_fix;
      default:                       result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (state == FIX) out <= result;
    end
  end

  assign busy = (state != IDLE);
  assign zero = (out == '0);

endmodule
